// File: rtl/pc_gen.sv
// Program-counter generator: architectural PC register with trap/redirect/return/stall
// arbitration and a small circular return-address stack for call/return prediction.
module pc_gen #(
  parameter int unsigned XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_1000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_2000,
  parameter int unsigned INSTR_BYTES  = 4,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_srst,
  input  logic            i_stall,
  input  logic            i_trap,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirectPc,
  input  logic            i_push,
  input  logic [XLEN-1:0] i_pushAddr,
  input  logic            i_ret,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pcPlus,
  output logic            o_valid,
  output logic            o_misaligned,
  output logic            o_rasEmpty,
  output logic            o_rasFull,
  output logic            o_rasUnderflow
);

  localparam int unsigned PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam int unsigned ALIGN_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

  localparam logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_VECTOR);
  localparam logic [XLEN-1:0]  TRAP_PC  = XLEN'(TRAP_VECTOR);
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(INSTR_BYTES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [XLEN-1:0]  pc_r;
  logic             valid_r;
  logic             underflow_r;
  logic [XLEN-1:0]  ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_r;
  logic [CNT_W-1:0] ras_cnt_r;

  logic [XLEN-1:0]  pc_plus_s;
  logic [XLEN-1:0]  pc_next_s;
  logic [XLEN-1:0]  ras_top_s;
  logic [PTR_W-1:0] ras_ptr_inc_s;
  logic             ras_empty_s;
  logic             ras_full_s;
  logic             ret_req_s;
  logic             pop_s;
  logic             push_s;
  logic             flush_s;
  logic             underflow_s;

  assign pc_plus_s     = pc_r + PC_STEP;
  assign ras_top_s     = ras_mem_r[ras_ptr_r];
  assign ras_ptr_inc_s = ras_ptr_r + PTR_ONE;
  assign ras_empty_s   = (ras_cnt_r == {CNT_W{1'b0}});
  assign ras_full_s    = (ras_cnt_r == CNT_MAX);

  // Trap and redirect mask a return; nothing is accepted during warm-up.
  assign ret_req_s   = valid_r & i_ret & ~i_trap & ~i_redirect;
  assign pop_s       = ret_req_s & ~ras_empty_s;
  assign underflow_s = ret_req_s & ras_empty_s;
  assign flush_s     = valid_r & i_trap;
  // A call is redirect + push, so redirect lets a push through a stall.
  assign push_s      = valid_r & i_push & ~i_trap & (~i_stall | i_redirect);

  // Next-PC priority mux: trap, redirect, return, stall, sequential.
  always_comb begin
    pc_next_s = pc_plus_s;
    if (!valid_r) begin
      pc_next_s = pc_r;
    end else if (i_trap) begin
      pc_next_s = TRAP_PC;
    end else if (i_redirect) begin
      pc_next_s = i_redirectPc;
    end else if (pop_s) begin
      pc_next_s = ras_top_s;
    end else if (i_stall) begin
      pc_next_s = pc_r;
    end else begin
      pc_next_s = pc_plus_s;
    end
  end

  // PC, warm-up valid flag and underflow pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      pc_r        <= RESET_PC;
      valid_r     <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      pc_r        <= pc_next_s;
      valid_r     <= 1'b1;
      underflow_r <= underflow_s;
    end
  end

  // Return-address stack: ras_ptr_r addresses the current top entry.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      ras_ptr_r <= {PTR_W{1'b0}};
      ras_cnt_r <= {CNT_W{1'b0}};
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_mem_r[i] <= {XLEN{1'b0}};
      end
    end else if (flush_s) begin
      ras_cnt_r <= {CNT_W{1'b0}};
    end else if (push_s && pop_s) begin
      // Top has just been consumed by the PC; the new return address reuses its slot.
      ras_mem_r[ras_ptr_r] <= i_pushAddr;
    end else if (push_s) begin
      ras_ptr_r                <= ras_ptr_inc_s;
      ras_mem_r[ras_ptr_inc_s] <= i_pushAddr;
      if (!ras_full_s) begin
        ras_cnt_r <= ras_cnt_r + CNT_ONE;
      end
    end else if (pop_s) begin
      ras_ptr_r <= ras_ptr_r - PTR_ONE;
      ras_cnt_r <= ras_cnt_r - CNT_ONE;
    end
  end

  assign o_pc           = pc_r;
  assign o_pcPlus       = pc_plus_s;
  assign o_valid        = valid_r;
  assign o_misaligned   = (pc_r[ALIGN_W-1:0] != {ALIGN_W{1'b0}});
  assign o_rasEmpty     = ras_empty_s;
  assign o_rasFull      = ras_full_s;
  assign o_rasUnderflow = underflow_r;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 32-bit instance for arbitration and RAS behaviour,
// and a 16-bit instance for address wrap-around.
module tb_pc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit DUT stimulus and outputs
  logic        srst, stall, trap, redir, push, ret;
  logic [31:0] rpc, paddr;
  logic [31:0] pc, pcplus;
  logic        valid, mis, rempty, rfull, ruf;

  // 16-bit DUT stimulus and outputs
  logic        srst16, redir16;
  logic [15:0] rpc16;
  logic [15:0] pc16, pcplus16;
  logic        valid16, mis16, rempty16, rfull16, ruf16;

  pc_gen dut (
    .i_clk(clk), .i_srst(srst), .i_stall(stall), .i_trap(trap),
    .i_redirect(redir), .i_redirectPc(rpc), .i_push(push), .i_pushAddr(paddr),
    .i_ret(ret), .o_pc(pc), .o_pcPlus(pcplus), .o_valid(valid),
    .o_misaligned(mis), .o_rasEmpty(rempty), .o_rasFull(rfull),
    .o_rasUnderflow(ruf)
  );

  pc_gen #(.XLEN(16)) dut16 (
    .i_clk(clk), .i_srst(srst16), .i_stall(1'b0), .i_trap(1'b0),
    .i_redirect(redir16), .i_redirectPc(rpc16), .i_push(1'b0),
    .i_pushAddr(16'h0000), .i_ret(1'b0), .o_pc(pc16), .o_pcPlus(pcplus16),
    .o_valid(valid16), .o_misaligned(mis16), .o_rasEmpty(rempty16),
    .o_rasFull(rfull16), .o_rasUnderflow(ruf16)
  );

  typedef struct {
    string       nm;
    bit          sel;   // 0: 32-bit DUT, 1: 16-bit DUT
    logic [31:0] pc;
    logic [31:0] pcplus;
    logic        v, m, e, f, u;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: the DUT presents a new state every cycle; check it on the falling edge.
  initial begin
    exp_t        x;
    logic [68:0] act, req;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        if (x.sel)
          act = {16'h0000, pc16, 16'h0000, pcplus16, valid16, mis16, rempty16, rfull16, ruf16};
        else
          act = {pc, pcplus, valid, mis, rempty, rfull, ruf};
        req = {x.pc, x.pcplus, x.v, x.m, x.e, x.f, x.u};
        n_tests++;
        if (act !== req) begin
          n_fail++;
          $display("FAIL %s: got pc=%h plus=%h v=%b mis=%b emp=%b full=%b uf=%b, want pc=%h plus=%h v=%b mis=%b emp=%b full=%b uf=%b",
                   x.nm, act[68:37], act[36:5], act[4], act[3], act[2], act[1], act[0],
                   x.pc, x.pcplus, x.v, x.m, x.e, x.f, x.u);
        end
      end
    end
  end

  // One cycle on the 32-bit DUT, then queue the state expected after the edge.
  task automatic step(input string nm, input logic s_srst, input logic s_stall,
                      input logic s_trap, input logic s_redir, input logic [31:0] s_rpc,
                      input logic s_push, input logic [31:0] s_paddr, input logic s_ret,
                      input logic [31:0] e_pc, input logic e_v, input logic e_e,
                      input logic e_f, input logic e_u);
    exp_t x;
    srst = s_srst; stall = s_stall; trap = s_trap; redir = s_redir; rpc = s_rpc;
    push = s_push; paddr = s_paddr; ret = s_ret;
    @(posedge clk); #1;
    x.nm = nm; x.sel = 1'b0; x.pc = e_pc; x.pcplus = e_pc + 32'd4;
    x.v = e_v; x.m = (e_pc[1:0] != 2'b00); x.e = e_e; x.f = e_f; x.u = e_u;
    q.push_back(x);
  endtask

  // One cycle on the 16-bit DUT; expected pc+4 is given by hand.
  task automatic step16(input string nm, input logic s_srst, input logic s_redir,
                        input logic [15:0] s_rpc, input logic [15:0] e_pc,
                        input logic [15:0] e_plus, input logic e_v);
    exp_t x;
    srst16 = s_srst; redir16 = s_redir; rpc16 = s_rpc;
    @(posedge clk); #1;
    x.nm = nm; x.sel = 1'b1; x.pc = {16'h0000, e_pc}; x.pcplus = {16'h0000, e_plus};
    x.v = e_v; x.m = (e_pc[1:0] != 2'b00); x.e = 1'b1; x.f = 1'b0; x.u = 1'b0;
    q.push_back(x);
  endtask

  localparam logic [31:0] Z = 32'h0;

  initial begin
    srst = 1'b1; stall = 1'b0; trap = 1'b0; redir = 1'b0; push = 1'b0; ret = 1'b0;
    rpc = Z; paddr = Z;
    srst16 = 1'b1; redir16 = 1'b0; rpc16 = 16'h0000;

    // name          srst stl trp red rpc           psh paddr         ret  pc            v    e    f    u
    step("reset0",   1'b1,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_1000,1'b0,1'b1,1'b0,1'b0);
    step("reset1",   1'b1,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_1000,1'b0,1'b1,1'b0,1'b0);
    step("warmup",   1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_1000,1'b1,1'b1,1'b0,1'b0);
    step("seq1",     1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_1004,1'b1,1'b1,1'b0,1'b0);
    step("seq2",     1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_1008,1'b1,1'b1,1'b0,1'b0);
    step("stl_redir",1'b0,1'b1,1'b0,1'b1,32'h3000,   1'b0,Z,          1'b0,32'h0000_3000,1'b1,1'b1,1'b0,1'b0);
    step("stall",    1'b0,1'b1,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_3000,1'b1,1'b1,1'b0,1'b0);
    step("call",     1'b0,1'b0,1'b0,1'b1,32'h4000,   1'b1,32'h1010,   1'b0,32'h0000_4000,1'b1,1'b0,1'b0,1'b0);
    step("callee1",  1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_4004,1'b1,1'b0,1'b0,1'b0);
    step("callee2",  1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_4008,1'b1,1'b0,1'b0,1'b0);
    step("return",   1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b1,32'h0000_1010,1'b1,1'b1,1'b0,1'b0);
    step("ret_empty",1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b1,32'h0000_1014,1'b1,1'b1,1'b0,1'b1);
    step("uf_clear", 1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_1018,1'b1,1'b1,1'b0,1'b0);
    step("push_seq", 1'b0,1'b0,1'b0,1'b0,Z,          1'b1,32'h5000,   1'b0,32'h0000_101C,1'b1,1'b0,1'b0,1'b0);
    step("trap_flsh",1'b0,1'b0,1'b1,1'b1,32'h3000,   1'b1,32'h6000,   1'b0,32'h0000_2000,1'b1,1'b1,1'b0,1'b0);
    step("post_trap",1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_2004,1'b1,1'b1,1'b0,1'b0);
    step("push_A",   1'b0,1'b0,1'b0,1'b0,Z,          1'b1,32'h0A00,   1'b0,32'h0000_2008,1'b1,1'b0,1'b0,1'b0);
    step("push_B",   1'b0,1'b0,1'b0,1'b0,Z,          1'b1,32'h0B00,   1'b0,32'h0000_200C,1'b1,1'b0,1'b0,1'b0);
    step("push_C",   1'b0,1'b0,1'b0,1'b0,Z,          1'b1,32'h0C00,   1'b0,32'h0000_2010,1'b1,1'b0,1'b0,1'b0);
    step("push_D",   1'b0,1'b0,1'b0,1'b0,Z,          1'b1,32'h0D00,   1'b0,32'h0000_2014,1'b1,1'b0,1'b1,1'b0);
    step("push_E",   1'b0,1'b0,1'b0,1'b0,Z,          1'b1,32'h0E00,   1'b0,32'h0000_2018,1'b1,1'b0,1'b1,1'b0);
    step("pop_E",    1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b1,32'h0000_0E00,1'b1,1'b0,1'b0,1'b0);
    step("pop_D",    1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b1,32'h0000_0D00,1'b1,1'b0,1'b0,1'b0);
    step("pop_C",    1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b1,32'h0000_0C00,1'b1,1'b0,1'b0,1'b0);
    step("pop_B",    1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b1,32'h0000_0B00,1'b1,1'b1,1'b0,1'b0);
    step("pop_uf",   1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b1,32'h0000_0B04,1'b1,1'b1,1'b0,1'b1);
    step("uf_clr2",  1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_0B08,1'b1,1'b1,1'b0,1'b0);
    step("push_1100",1'b0,1'b0,1'b0,1'b0,Z,          1'b1,32'h1100,   1'b0,32'h0000_0B0C,1'b1,1'b0,1'b0,1'b0);
    step("push_ret", 1'b0,1'b0,1'b0,1'b0,Z,          1'b1,32'h1200,   1'b1,32'h0000_1100,1'b1,1'b0,1'b0,1'b0);
    step("ret_1200", 1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b1,32'h0000_1200,1'b1,1'b1,1'b0,1'b0);
    step("seq_1204", 1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_1204,1'b1,1'b1,1'b0,1'b0);
    step("stl_push", 1'b0,1'b1,1'b0,1'b0,Z,          1'b1,32'h7000,   1'b0,32'h0000_1204,1'b1,1'b1,1'b0,1'b0);
    step("stl_retuf",1'b0,1'b1,1'b0,1'b0,Z,          1'b0,Z,          1'b1,32'h0000_1204,1'b1,1'b1,1'b0,1'b1);
    step("seq_1208", 1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_1208,1'b1,1'b1,1'b0,1'b0);
    step("misalign", 1'b0,1'b0,1'b0,1'b1,32'h3002,   1'b0,Z,          1'b0,32'h0000_3002,1'b1,1'b1,1'b0,1'b0);
    step("mis_inc",  1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_3006,1'b1,1'b1,1'b0,1'b0);
    step("srst_wins",1'b1,1'b0,1'b0,1'b1,32'h9000,   1'b1,32'h8000,   1'b0,32'h0000_1000,1'b0,1'b1,1'b0,1'b0);
    step("warm_ign", 1'b0,1'b0,1'b1,1'b1,32'h9000,   1'b1,32'h8000,   1'b1,32'h0000_1000,1'b1,1'b1,1'b0,1'b0);
    step("seq_r1",   1'b0,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_1004,1'b1,1'b1,1'b0,1'b0);
    step("push_mid", 1'b0,1'b0,1'b0,1'b0,Z,          1'b1,32'h1234,   1'b0,32'h0000_1008,1'b1,1'b0,1'b0,1'b0);
    step("mid_reset",1'b1,1'b0,1'b0,1'b0,Z,          1'b0,Z,          1'b0,32'h0000_1000,1'b0,1'b1,1'b0,1'b0);
    srst = 1'b0;

    // 16-bit wrap-around
    step16("w16_rst",  1'b1, 1'b0, 16'h0000, 16'h1000, 16'h1004, 1'b0);
    step16("w16_warm", 1'b0, 1'b0, 16'h0000, 16'h1000, 16'h1004, 1'b1);
    step16("w16_redir",1'b0, 1'b1, 16'hFFFC, 16'hFFFC, 16'h0000, 1'b1);
    step16("w16_wrap", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0004, 1'b1);
    step16("w16_seq",  1'b0, 1'b0, 16'h0000, 16'h0004, 16'h0008, 1'b1);

    repeat (3) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
